stream_fifo: RTL and testbench

- Parametrised synchronous FIFO with valid/ready handshakes on both the write (sink) and read (source) sides.
- Generalises the single-clock source FIFO in width and depth, and adds almost-full/almost-empty thresholds, an occupancy count, a high-water mark and a synchronous flush.
- Sits between a producer and a downstream consumer on the clk domain.
- Output is registered and data/valid are held stable under backpressure.

---
 rtl/stream_fifo_if.sv | 33 +++
 rtl/stream_fifo.sv | 99 +++++++++
 tb/tb_stream_fifo.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle for stream_fifo: sink (write) and source (read) handshakes
// plus occupancy status.
interface stream_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             sink_valid;
  logic             sink_ready;
  logic [WIDTH-1:0] sink_data;
  logic             source_valid;
  logic             source_ready;
  logic [WIDTH-1:0] source_data;
  logic [CW-1:0]    count;
  logic [CW-1:0]    hwm;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;

  modport slave (
    input  sink_valid, sink_data, source_ready,
    output sink_ready, source_valid, source_data, count, hwm,
           fifo_full, fifo_empty, almost_full, almost_empty
  );

  modport master (
    output sink_valid, sink_data, source_ready,
    input  sink_ready, source_valid, source_data, count, hwm,
           fifo_full, fifo_empty, almost_full, almost_empty
  );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO: a DEPTH-1 entry RAM ring feeding one registered output
// stage, with occupancy count, threshold flags, high-water mark and synchronous flush.
module stream_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  stream_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RD = DEPTH - 1;
  localparam int PW = (RD > 1) ? $clog2(RD) : 1;

  logic [WIDTH-1:0] mem_q [RD];

  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    hwm_q, hwm_d;
  logic [CW-1:0]    ram_cnt;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic full, push, pop, out_free, ram_empty, load_ram, bypass, ram_wr;

  // Explicit wrap keeps the ring correct for any RAM size, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 2)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign push      = bus.sink_valid && !full;
  assign pop       = out_valid_q && bus.source_ready;
  assign ram_cnt   = count_q - CW'(out_valid_q);
  assign ram_empty = (ram_cnt == '0);
  assign out_free  = !out_valid_q || pop;
  assign load_ram  = out_free && !ram_empty;
  assign bypass    = out_free && ram_empty && push;
  assign ram_wr    = push && !bypass;

  always_comb begin
    out_valid_d = (out_valid_q && !pop) || load_ram || bypass;
    out_data_d  = out_data_q;
    if (load_ram) begin
      out_data_d = mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_data_d = bus.sink_data;
    end
    wr_ptr_d = ram_wr   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = load_ram ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    hwm_d    = (count_d > hwm_q) ? count_d : hwm_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q     <= '0;
      hwm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      count_q     <= '0;
      hwm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      hwm_q       <= hwm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage is deliberately left unreset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (ram_wr && !flush) begin
      mem_q[wr_ptr_q] <= bus.sink_data;
    end
  end

  assign bus.sink_ready   = !full;
  assign bus.source_valid = out_valid_q;
  assign bus.source_data  = out_data_q;
  assign bus.count        = count_q;
  assign bus.hwm          = hwm_q;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = (count_q == '0);
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: default 16-deep instance plus a 5-deep instance for
// non-power-of-two pointer wrap.
module tb_stream_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_fifo_if #(.WIDTH(8), .DEPTH(16)) bus16 ();
  stream_fifo_if #(.WIDTH(8), .DEPTH(5))  bus5 ();

  stream_fifo #(.WIDTH(8), .DEPTH(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus16)
  );
  stream_fifo #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int sent, got, cyc;
    logic sv, sr, p_push, p_pop;

    bus16.sink_valid = 0; bus16.sink_data = 0; bus16.source_ready = 0;
    bus5.sink_valid  = 0; bus5.sink_data  = 0; bus5.source_ready  = 0;

    // reset then idle
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_count", 32'(bus16.count), 0);
    chk("rst_empty", 32'(bus16.fifo_empty), 1);
    chk("rst_full", 32'(bus16.fifo_full), 0);
    chk("rst_sink_ready", 32'(bus16.sink_ready), 1);
    chk("rst_src_valid", 32'(bus16.source_valid), 0);
    chk("rst_hwm", 32'(bus16.hwm), 0);
    chk("rst_ae", 32'(bus16.almost_empty), 1);
    chk("rst_af", 32'(bus16.almost_full), 0);
    step();

    // fill 0x01..0x10 with no consumer
    for (int i = 1; i <= 16; i++) begin
      bus16.sink_valid = 1; bus16.sink_data = 8'(i);
      chk("fill_sink_ready", 32'(bus16.sink_ready), 1);
      step();
      chk("fill_count", 32'(bus16.count), 32'(i));
      chk("fill_af", 32'(bus16.almost_full), (i >= 14) ? 1 : 0);
      chk("fill_src_valid", 32'(bus16.source_valid), 1);
      chk("fill_hold_data", 32'(bus16.source_data), 32'h01);
    end
    bus16.sink_valid = 0;
    chk("full_flag", 32'(bus16.fifo_full), 1);
    chk("full_sink_ready", 32'(bus16.sink_ready), 0);
    chk("full_hwm", 32'(bus16.hwm), 16);

    // drain in order
    bus16.source_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(bus16.source_data), 32'(i));
      chk("drain_valid", 32'(bus16.source_valid), 1);
      step();
      chk("drain_count", 32'(bus16.count), 32'(16 - i));
      chk("drain_ae", 32'(bus16.almost_empty), (16 - i <= 2) ? 1 : 0);
    end
    bus16.source_ready = 0;
    chk("drain_empty", 32'(bus16.fifo_empty), 1);
    chk("drain_valid_end", 32'(bus16.source_valid), 0);
    chk("drain_hwm", 32'(bus16.hwm), 16);

    // full with simultaneous pop: push refused, retried next cycle
    for (int i = 1; i <= 16; i++) begin
      bus16.sink_valid = 1; bus16.sink_data = 8'(32'h20 + i);
      step();
    end
    chk("refill_count", 32'(bus16.count), 16);
    bus16.sink_data = 8'hAA; bus16.source_ready = 1;
    chk("fullpop_sink_ready", 32'(bus16.sink_ready), 0);
    chk("fullpop_head", 32'(bus16.source_data), 32'h21);
    step();
    chk("fullpop_count", 32'(bus16.count), 15);
    chk("fullpop_next", 32'(bus16.source_data), 32'h22);
    bus16.source_ready = 0;
    step();
    chk("retry_count", 32'(bus16.count), 16);
    bus16.sink_valid = 0; bus16.source_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("retry_order", 32'(bus16.source_data), (i < 15) ? 32'h22 + 32'(i) : 32'hAA);
      step();
    end
    bus16.source_ready = 0;
    chk("retry_empty", 32'(bus16.fifo_empty), 1);

    // flush at count 7 with a concurrent push
    for (int i = 0; i < 7; i++) begin
      bus16.sink_valid = 1; bus16.sink_data = 8'(32'h40 + i);
      step();
    end
    chk("preflush_count", 32'(bus16.count), 7);
    flush = 1; bus16.sink_data = 8'hEE;
    step();
    flush = 0; bus16.sink_valid = 0;
    chk("flush_count", 32'(bus16.count), 0);
    chk("flush_valid", 32'(bus16.source_valid), 0);
    chk("flush_hwm", 32'(bus16.hwm), 0);
    chk("flush_empty", 32'(bus16.fifo_empty), 1);
    step();
    chk("flush_stays_empty", 32'(bus16.count), 0);
    bus16.sink_valid = 1; bus16.sink_data = 8'h55;
    step();
    bus16.sink_valid = 0;
    chk("postflush_data", 32'(bus16.source_data), 32'h55);
    chk("postflush_count", 32'(bus16.count), 1);
    chk("postflush_hwm", 32'(bus16.hwm), 1);
    bus16.source_ready = 1;
    step();
    bus16.source_ready = 0;
    chk("postflush_drained", 32'(bus16.source_valid), 0);

    // async reset at count 9
    for (int i = 0; i < 9; i++) begin
      bus16.sink_valid = 1; bus16.sink_data = 8'(32'h60 + i);
      step();
    end
    bus16.sink_valid = 0;
    chk("prerst_count", 32'(bus16.count), 9);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_count", 32'(bus16.count), 0);
    chk("midrst_valid", 32'(bus16.source_valid), 0);
    chk("midrst_data", 32'(bus16.source_data), 0);
    chk("midrst_hwm", 32'(bus16.hwm), 0);
    chk("midrst_empty", 32'(bus16.fifo_empty), 1);
    chk("midrst_sink_ready", 32'(bus16.sink_ready), 1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // streaming on both depths
    bus16.sink_valid = 1; bus16.source_ready = 1;
    bus5.sink_valid  = 1; bus5.source_ready  = 1;
    for (int k = 0; k < 100; k++) begin
      bus16.sink_data = 8'(k); bus5.sink_data = 8'(k);
      step();
      chk("stream16_valid", 32'(bus16.source_valid), 1);
      chk("stream16_data", 32'(bus16.source_data), 32'(k));
      chk("stream16_count", 32'(bus16.count), 1);
      chk("stream5_data", 32'(bus5.source_data), 32'(k));
      chk("stream5_count", 32'(bus5.count), 1);
    end
    bus16.sink_valid = 0; bus5.sink_valid = 0;
    step();
    bus16.source_ready = 0; bus5.source_ready = 0;
    chk("stream16_end", 32'(bus16.fifo_empty), 1);
    chk("stream5_end", 32'(bus5.fifo_empty), 1);

    // DEPTH=5 with random stalls against a queue model
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      sv = (sent < 100) && ($urandom_range(0, 3) != 0);
      sr = ($urandom_range(0, 2) != 0);
      bus5.sink_valid = sv; bus5.sink_data = sent[7:0]; bus5.source_ready = sr;
      chk("rand5_count", 32'(bus5.count), 32'(q.size()));
      chk("rand5_sink_ready", 32'(bus5.sink_ready), (q.size() < 5) ? 1 : 0);
      chk("rand5_valid", 32'(bus5.source_valid), (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) chk("rand5_data", 32'(bus5.source_data), 32'(q[0]));
      p_pop  = (q.size() != 0) && sr;
      p_push = sv && (q.size() < 5);
      step();
      if (p_pop) begin
        void'(q.pop_front());
        got++;
      end
      if (p_push) begin
        q.push_back(sent[7:0]);
        sent++;
      end
      cyc++;
    end
    bus5.sink_valid = 0; bus5.source_ready = 0;
    chk("rand5_delivered", 32'(got), 100);
    chk("rand5_hwm", 32'(bus5.hwm), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
